// File: rtl/keccak_arbiter_ctrl.sv
// Shares one Keccak-f[1600] core among NREQ requesters: round-robin ownership,
// word-granular access to a 1600-bit state buffer, and permutation start/collect.
module keccak_arbiter_ctrl #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned WORDS = 50
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NREQ-1:0]     req_valid_i,
  output logic [NREQ-1:0]     req_ready_o,
  input  logic [2*NREQ-1:0]   req_op_i,
  input  logic [6*NREQ-1:0]   req_idx_i,
  input  logic [32*NREQ-1:0]  req_wdata_i,
  output logic [NREQ-1:0]     rsp_valid_o,
  output logic [31:0]         rsp_rdata_o,
  output logic                rsp_err_o,
  output logic [NREQ-1:0]     owner_o,
  output logic                busy_o,
  output logic                kc_start_o,
  output logic [32*WORDS-1:0] kc_din_o,
  input  logic [32*WORDS-1:0] kc_dout_i,
  input  logic                kc_done_i
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_FREE, S_OWNED, S_START, S_BUSY} state_e;
  typedef enum logic [1:0] {
    OP_WRITE   = 2'b00,
    OP_START   = 2'b01,
    OP_READ    = 2'b10,
    OP_RELEASE = 2'b11
  } op_e;

  state_e              state_q, state_d;
  logic [NREQ-1:0]     owner_q;
  logic [PW-1:0]       rr_ptr_q;
  logic [32*WORDS-1:0] buf_q;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grant_idx;
  logic            accept;
  op_e             sel_op;
  logic [5:0]      sel_idx;
  logic [31:0]     sel_wdata;
  logic [31:0]     rd_word;
  logic            in_range;

  // Round-robin search starting at rr_ptr_q; first valid requester wins.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    logic          found;
    logic [PW-1:0] cand;
    found     = 1'b0;
    cand      = '0;
    grant     = '0;
    grant_idx = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = PW'((32'(rr_ptr_q) + off) % NREQ);
      if (!found && req_valid_i[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Ready depends only on state, owner and valid -- never on the op field.
  always_comb begin
    req_ready_o = '0;
    case (state_q)
      S_FREE:  req_ready_o = grant;
      S_OWNED: req_ready_o = owner_q & req_valid_i;
      default: req_ready_o = '0;
    endcase
  end

  assign accept = |req_ready_o;

  always_comb begin
    sel_op    = OP_WRITE;
    sel_idx   = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_ready_o[i]) begin
        sel_op    = op_e'(req_op_i[2*i +: 2]);
        sel_idx   = req_idx_i[6*i +: 6];
        sel_wdata = req_wdata_i[32*i +: 32];
      end
    end
  end

  assign in_range = ({26'd0, sel_idx} < WORDS);

  always_comb begin
    rd_word = '0;
    for (int unsigned w = 0; w < WORDS; w++) begin
      if (sel_idx == 6'(w)) rd_word = buf_q[32*w +: 32];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FREE, S_OWNED: begin
        if (accept) begin
          case (sel_op)
            OP_RELEASE: state_d = S_FREE;
            OP_START:   state_d = S_START;
            default:    state_d = S_OWNED;
          endcase
        end
      end
      S_START: state_d = S_BUSY;
      S_BUSY:  if (kc_done_i) state_d = S_OWNED;
      default: state_d = S_FREE;
    endcase
  end

  // NOTE: the state buffer is reset explicitly -- a stale state must never leak to the next owner.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_FREE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      buf_q       <= '0;
      rsp_valid_o <= '0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_o <= req_ready_o;
      rsp_err_o   <= accept && (sel_op == OP_WRITE || sel_op == OP_READ) && !in_range;
      rsp_rdata_o <= (accept && sel_op == OP_READ && in_range) ? rd_word : '0;

      if (accept) owner_q <= (sel_op == OP_RELEASE) ? '0 : req_ready_o;

      if (state_q == S_FREE && accept)
        rr_ptr_q <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

      if (state_q == S_BUSY && kc_done_i) begin
        buf_q <= kc_dout_i;
      end else if (accept && sel_op == OP_RELEASE) begin
        buf_q <= '0;
      end else if (accept && sel_op == OP_WRITE) begin
        for (int unsigned w = 0; w < WORDS; w++) begin
          if (sel_idx == 6'(w)) buf_q[32*w +: 32] <= sel_wdata;
        end
      end
    end
  end

  assign owner_o    = owner_q;
  assign busy_o     = (state_q == S_START) || (state_q == S_BUSY);
  assign kc_start_o = (state_q == S_START);
  assign kc_din_o   = buf_q;

endmodule

// File: tb/tb_keccak_arbiter_ctrl.sv
// Directed bench for keccak_arbiter_ctrl: arbitration, buffer access, permutation
// handshake, error cases and reset during a permutation.
module tb_keccak_arbiter_ctrl;

  localparam int NREQ  = 2;
  localparam int WORDS = 50;

  localparam logic [1:0] OP_WRITE   = 2'b00;
  localparam logic [1:0] OP_START   = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] OP_RELEASE = 2'b11;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [NREQ-1:0]     req_valid_i;
  logic [NREQ-1:0]     req_ready_o;
  logic [2*NREQ-1:0]   req_op_i;
  logic [6*NREQ-1:0]   req_idx_i;
  logic [32*NREQ-1:0]  req_wdata_i;
  logic [NREQ-1:0]     rsp_valid_o;
  logic [31:0]         rsp_rdata_o;
  logic                rsp_err_o;
  logic [NREQ-1:0]     owner_o;
  logic                busy_o;
  logic                kc_start_o;
  logic [32*WORDS-1:0] kc_din_o;
  logic [32*WORDS-1:0] kc_dout_i;
  logic                kc_done_i;

  logic [32*WORDS-1:0] exp_buf;
  logic [32*WORDS-1:0] dout_pat;
  int checks = 0;
  int errors = 0;

  keccak_arbiter_ctrl #(.NREQ(NREQ), .WORDS(WORDS)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_op_i    (req_op_i),
    .req_idx_i   (req_idx_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .owner_o     (owner_o),
    .busy_o      (busy_o),
    .kc_start_o  (kc_start_o),
    .kc_din_o    (kc_din_o),
    .kc_dout_i   (kc_dout_i),
    .kc_done_i   (kc_done_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_buf(input string tag, input logic [32*WORDS-1:0] exp);
    int bad;
    bad = -1;
    for (int w = WORDS - 1; w >= 0; w--) begin
      if (kc_din_o[32*w +: 32] !== exp[32*w +: 32]) bad = w;
    end
    checks++;
    assert (kc_din_o === exp) else begin
      errors++;
      $error("FAIL %s first bad word %0d observed %h expected %h", tag, bad,
             kc_din_o[32*bad +: 32], exp[32*bad +: 32]);
    end
  endtask

  task automatic drive(input int r, input logic v, input logic [1:0] op,
                       input logic [5:0] idx, input logic [31:0] wd);
    req_valid_i[r]         = v;
    req_op_i[2*r +: 2]     = op;
    req_idx_i[6*r +: 6]    = idx;
    req_wdata_i[32*r +: 32] = wd;
  endtask

  task automatic after_pos();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i       = 1'b1;
    req_valid_i = '0;
    req_op_i    = '0;
    req_idx_i   = '0;
    req_wdata_i = '0;
    kc_dout_i   = '0;
    kc_done_i   = 1'b0;
    exp_buf     = '0;
    for (int i = 0; i < WORDS; i++) dout_pat[32*i +: 32] = 32'hC0DE0000 + 32'(i);

    repeat (2) @(posedge clk_i);
    #1;
    check("rst_owner", 32'(owner_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_start", 32'(kc_start_o), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
    check("rst_rsp_err", 32'(rsp_err_o), 32'h0);
    check("rst_rdata", rsp_rdata_o, 32'h0);
    check_buf("rst_buf", exp_buf);

    // Both requesters contend after reset: requester 0 wins.
    @(negedge clk_i);
    rst_i = 1'b0;
    drive(0, 1'b1, OP_READ, 6'd0, 32'h0);
    drive(1, 1'b1, OP_READ, 6'd0, 32'h0);
    #1 check("rr_first_ready", 32'(req_ready_o), 32'h1);
    after_pos();
    check("rr_first_owner", 32'(owner_o), 32'h1);
    check("rr_first_rsp", 32'(rsp_valid_o), 32'h1);
    check("rr_first_rdata", rsp_rdata_o, 32'h0);

    @(negedge clk_i);
    drive(0, 1'b1, OP_RELEASE, 6'd0, 32'h0);
    #1 check("owned_ready_owner_only", 32'(req_ready_o), 32'h1);
    after_pos();
    check("release_owner", 32'(owner_o), 32'h0);
    check("release_rsp", 32'(rsp_valid_o), 32'h1);

    // Both still valid: pointer has moved past requester 0.
    @(negedge clk_i);
    drive(0, 1'b1, OP_READ, 6'd0, 32'h0);
    drive(1, 1'b1, OP_WRITE, 6'd0, 32'h00000006);
    #1 check("rr_second_ready", 32'(req_ready_o), 32'h2);
    after_pos();
    exp_buf[31:0] = 32'h00000006;
    check("rr_second_owner", 32'(owner_o), 32'h2);
    check("rr_second_rsp", 32'(rsp_valid_o), 32'h2);
    check_buf("write_idx0", exp_buf);

    @(negedge clk_i);
    drive(0, 1'b0, OP_READ, 6'd0, 32'h0);
    drive(1, 1'b1, OP_WRITE, 6'd33, 32'h80000000);
    after_pos();
    exp_buf[32*33 +: 32] = 32'h80000000;
    check("write33_err", 32'(rsp_err_o), 32'h0);
    check_buf("write_idx33", exp_buf);

    @(negedge clk_i);
    drive(1, 1'b1, OP_START, 6'd0, 32'h0);
    after_pos();
    check("start_pulse_hi", 32'(kc_start_o), 32'h1);
    check("start_busy", 32'(busy_o), 32'h1);
    check("start_rsp", 32'(rsp_valid_o), 32'h2);
    check("start_rdata", rsp_rdata_o, 32'h0);

    @(negedge clk_i);
    drive(1, 1'b1, OP_READ, 6'd0, 32'h0);
    #1 check("start_ready_low", 32'(req_ready_o), 32'h0);
    after_pos();
    check("start_pulse_lo", 32'(kc_start_o), 32'h0);
    check("busy_hold", 32'(busy_o), 32'h1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      #1;
      check("busy_ready_low", 32'(req_ready_o), 32'h0);
      check("busy_no_rsp", 32'(rsp_valid_o), 32'h0);
      check("busy_no_start", 32'(kc_start_o), 32'h0);
      check("busy_flag", 32'(busy_o), 32'h1);
    end

    @(negedge clk_i);
    kc_dout_i = dout_pat;
    kc_done_i = 1'b1;
    #1 check("done_cycle_busy", 32'(busy_o), 32'h1);
    after_pos();
    exp_buf = dout_pat;
    check("done_busy_clear", 32'(busy_o), 32'h0);
    check_buf("done_load", exp_buf);

    @(negedge clk_i);
    kc_done_i = 1'b0;
    after_pos();
    check("read0_rsp", 32'(rsp_valid_o), 32'h2);
    check("read0_rdata", rsp_rdata_o, 32'hC0DE0000);

    // Out-of-range accesses and the last legal word.
    @(negedge clk_i);
    drive(1, 1'b1, OP_WRITE, 6'd50, 32'hDEADBEEF);
    after_pos();
    check("write50_err", 32'(rsp_err_o), 32'h1);
    check("write50_rdata", rsp_rdata_o, 32'h0);
    check("write50_rsp", 32'(rsp_valid_o), 32'h2);
    check_buf("write50_buf", exp_buf);

    @(negedge clk_i);
    drive(1, 1'b1, OP_READ, 6'd63, 32'h0);
    after_pos();
    check("read63_err", 32'(rsp_err_o), 32'h1);
    check("read63_rdata", rsp_rdata_o, 32'h0);

    @(negedge clk_i);
    drive(1, 1'b1, OP_READ, 6'd49, 32'h0);
    after_pos();
    check("read49_err", 32'(rsp_err_o), 32'h0);
    check("read49_rdata", rsp_rdata_o, 32'hC0DE0031);

    @(negedge clk_i);
    drive(1, 1'b1, OP_WRITE, 6'd49, 32'h12345678);
    after_pos();
    exp_buf[32*49 +: 32] = 32'h12345678;
    check("write49_err", 32'(rsp_err_o), 32'h0);
    check_buf("write49_buf", exp_buf);

    // Stray done while owned is ignored.
    @(negedge clk_i);
    drive(1, 1'b0, OP_READ, 6'd0, 32'h0);
    kc_dout_i = '1;
    kc_done_i = 1'b1;
    after_pos();
    check_buf("stray_done_buf", exp_buf);
    check("stray_done_busy", 32'(busy_o), 32'h0);
    check("stray_done_rsp", 32'(rsp_valid_o), 32'h0);

    // Non-owner holds a RELEASE for 20 cycles while locked out.
    @(negedge clk_i);
    kc_done_i = 1'b0;
    drive(0, 1'b1, OP_RELEASE, 6'd0, 32'h0);
    for (int c = 0; c < 20; c++) begin
      #1 check("locked_ready", 32'(req_ready_o), 32'h0);
      @(negedge clk_i);
    end
    check("locked_owner", 32'(owner_o), 32'h2);
    check("locked_no_rsp", 32'(rsp_valid_o), 32'h0);

    drive(0, 1'b1, OP_READ, 6'd5, 32'h0);
    drive(1, 1'b1, OP_RELEASE, 6'd0, 32'h0);
    #1 check("owner_release_ready", 32'(req_ready_o), 32'h2);
    after_pos();
    exp_buf = '0;
    check("owner_release_owner", 32'(owner_o), 32'h0);
    check("owner_release_rsp", 32'(rsp_valid_o), 32'h2);
    check_buf("owner_release_buf", exp_buf);
    check("handover_ready", 32'(req_ready_o), 32'h1);

    @(negedge clk_i);
    drive(1, 1'b0, OP_READ, 6'd0, 32'h0);
    after_pos();
    check("handover_owner", 32'(owner_o), 32'h1);
    check("handover_rsp", 32'(rsp_valid_o), 32'h1);
    check("handover_read5", rsp_rdata_o, 32'h0);
    check("handover_err", 32'(rsp_err_o), 32'h0);

    // Reset in the middle of a permutation.
    @(negedge clk_i);
    drive(0, 1'b1, OP_WRITE, 6'd3, 32'h00001234);
    after_pos();
    exp_buf[32*3 +: 32] = 32'h00001234;
    check_buf("pre_rst_write", exp_buf);
    @(negedge clk_i);
    drive(0, 1'b1, OP_START, 6'd0, 32'h0);
    after_pos();
    check("pre_rst_start", 32'(kc_start_o), 32'h1);
    @(negedge clk_i);
    drive(0, 1'b0, OP_READ, 6'd0, 32'h0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("pre_rst_busy", 32'(busy_o), 32'h1);
    #2 rst_i = 1'b1;
    #1;
    exp_buf = '0;
    check("rst_mid_busy", 32'(busy_o), 32'h0);
    check("rst_mid_owner", 32'(owner_o), 32'h0);
    check_buf("rst_mid_buf", exp_buf);

    @(negedge clk_i);
    rst_i     = 1'b0;
    kc_dout_i = dout_pat;
    kc_done_i = 1'b1;
    after_pos();
    check_buf("late_done_buf", exp_buf);
    check("late_done_busy", 32'(busy_o), 32'h0);
    check("late_done_owner", 32'(owner_o), 32'h0);
    check("late_done_rsp", 32'(rsp_valid_o), 32'h0);

    // Pointer was reset too: requester 0 wins again.
    @(negedge clk_i);
    kc_done_i = 1'b0;
    drive(0, 1'b1, OP_READ, 6'd0, 32'h0);
    drive(1, 1'b1, OP_READ, 6'd0, 32'h0);
    #1 check("rr_after_rst_ready", 32'(req_ready_o), 32'h1);
    after_pos();
    check("rr_after_rst_owner", 32'(owner_o), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
